// File: rtl/de2_sram_ctrl_if.sv
// Host-side request/response bus for de2_sram_ctrl.
// SRAM_CTRL_DBL_EN widens be/wdata/rdata to 32-bit words and adds the wide select.
interface de2_sram_ctrl_if;
`ifdef SRAM_CTRL_DBL_EN
    localparam int DW  = 32;
    localparam int BEW = 4;
`else
    localparam int DW  = 16;
    localparam int BEW = 2;
`endif

    logic           req;
    logic           we;
    logic [19:0]    addr;
    logic [BEW-1:0] be;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  rdata;
    logic           ack;
`ifdef SRAM_CTRL_DBL_EN
    logic           wide;

    modport master (output req, we, addr, be, wdata, wide, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, wide, output rdata, ack);
`else
    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);
`endif
endinterface

// File: rtl/de2_sram_ctrl.sv
// Asynchronous 16-bit SRAM controller (DE2 board IS61LV25616 style) with registered strobes.
// Define SRAM_CTRL_DBL_EN for 32-bit host words split into two consecutive SRAM accesses.
module de2_sram_ctrl #(
    parameter int WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    de2_sram_ctrl_if.slave    bus,
    output logic [19:0]       sram_addr,
    inout  wire  [15:0]       sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

`ifdef SRAM_CTRL_DBL_EN
    localparam int DW  = 32;
    localparam int BEW = 4;
`else
    localparam int DW  = 16;
    localparam int BEW = 2;
`endif

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_ACK      = 3'd5;

    localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

    logic [2:0]     state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [19:0]    addr_q, addr_d;
    logic           we_q, we_d;
    logic [BEW-1:0] be_q, be_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           ack_q, ack_d;
    logic           ce_n_q, ce_n_d;
    logic           oe_n_q, oe_n_d;
    logic           we_n_q, we_n_d;
    logic           ub_n_q, ub_n_d;
    logic           lb_n_q, lb_n_d;
    logic           dq_oe_q, dq_oe_d;
`ifdef SRAM_CTRL_DBL_EN
    logic           wide_q, wide_d;
    logic           phase_q, phase_d;
    logic [15:0]    rd_lo_q, rd_lo_d;
`endif

    logic [15:0]    rd_lane;
    logic           busy_d;

    // Disabled byte lanes read back as zero regardless of what the bus floats to.
    assign rd_lane = {be_q[1] ? sram_dq[15:8] : 8'h00,
                      be_q[0] ? sram_dq[7:0]  : 8'h00};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
`ifdef SRAM_CTRL_DBL_EN
        wide_d  = wide_q;
        phase_d = phase_q;
        rd_lo_d = rd_lo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    we_d    = bus.we;
                    be_d    = bus.be;
                    wdata_d = bus.wdata;
                    cnt_d   = CNT_INIT;
                    state_d = bus.we ? S_WR_SETUP : S_READ;
`ifdef SRAM_CTRL_DBL_EN
                    wide_d  = bus.wide;
                    phase_d = 1'b0;
`endif
                end
            end

            S_READ: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
`ifdef SRAM_CTRL_DBL_EN
                    if (wide_q && !phase_q) begin
                        // Low halfword done; re-arm READ for the upper halfword at addr+1.
                        rd_lo_d = rd_lane;
                        phase_d = 1'b1;
                        addr_d  = addr_q + 20'd1;
                        be_d    = {2'b00, be_q[3:2]};
                        cnt_d   = CNT_INIT;
                    end else begin
                        rdata_d = wide_q ? {rd_lane, rd_lo_q} : {16'h0000, rd_lane};
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                    end
`else
                    rdata_d = rd_lane;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
`endif
                end
            end

            S_WR_SETUP: begin
                cnt_d   = CNT_INIT;
                state_d = S_WR_PULSE;
            end

            S_WR_PULSE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_WR_HOLD;
                end
            end

            S_WR_HOLD: begin
`ifdef SRAM_CTRL_DBL_EN
                if (wide_q && !phase_q) begin
                    phase_d = 1'b1;
                    addr_d  = addr_q + 20'd1;
                    be_d    = {2'b00, be_q[3:2]};
                    wdata_d = {16'h0000, wdata_q[31:16]};
                    state_d = S_WR_SETUP;
                end else begin
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end
`else
                ack_d   = 1'b1;
                state_d = S_ACK;
`endif
            end

            S_ACK: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pin levels are decoded from the next state so every strobe leaves a flop.
        busy_d  = (state_d != S_IDLE) && (state_d != S_ACK);
        ce_n_d  = !busy_d;
        oe_n_d  = (state_d != S_READ);
        we_n_d  = (state_d != S_WR_PULSE);
        ub_n_d  = !busy_d || !be_d[1];
        lb_n_d  = !busy_d || !be_d[0];
        dq_oe_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                  (state_d == S_WR_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 20'd0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
`ifdef SRAM_CTRL_DBL_EN
            wide_q  <= 1'b0;
            phase_q <= 1'b0;
            rd_lo_q <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            dq_oe_q <= dq_oe_d;
`ifdef SRAM_CTRL_DBL_EN
            wide_q  <= wide_d;
            phase_q <= phase_d;
            rd_lo_q <= rd_lo_d;
`endif
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_ub_n = ub_n_q;
    assign sram_lb_n = lb_n_q;
    assign sram_dq   = dq_oe_q ? wdata_q[15:0] : 16'hzzzz;

endmodule

// File: tb/tb_de2_sram_ctrl.sv
// Directed bench for de2_sram_ctrl: a WAIT=1 instance backed by a word-array SRAM model,
// plus a WAIT=3 instance whose pin timing is counted cycle by cycle.
module tb_de2_sram_ctrl;

`ifdef SRAM_CTRL_DBL_EN
    localparam int DW  = 32;
    localparam int BEW = 4;
`else
    localparam int DW  = 16;
    localparam int BEW = 2;
`endif

    logic        clk;
    logic        reset;
    int          n_checks;
    int          n_errors;

    // WAIT=1 instance and its SRAM model
    de2_sram_ctrl_if bus();
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [15:0] mem [0:1048575];

    de2_sram_ctrl #(.WAIT(1)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
            if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
        end
    end

    // WAIT=3 instance; the bench answers reads with a fixed pattern
    de2_sram_ctrl_if bus3();
    logic [19:0] sram3_addr;
    wire  [15:0] sram3_dq;
    logic        sram3_ce_n, sram3_oe_n, sram3_we_n, sram3_ub_n, sram3_lb_n;

    de2_sram_ctrl #(.WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .sram_addr(sram3_addr), .sram_dq(sram3_dq),
        .sram_ce_n(sram3_ce_n), .sram_oe_n(sram3_oe_n), .sram_we_n(sram3_we_n),
        .sram_ub_n(sram3_ub_n), .sram_lb_n(sram3_lb_n)
    );

    assign sram3_dq = (!sram3_ce_n && !sram3_oe_n && sram3_we_n) ? 16'hA5C3 : 16'hzzzz;

    // Pin activity counters, sampled mid-cycle
    logic mon_en, mon3_en;
    int   lane_cnt, we3_low, drv3, drv3_we_high, oe3_low;

    always @(negedge clk) begin
        if (mon_en && (!sram_ub_n || !sram_lb_n)) lane_cnt++;
        if (mon3_en) begin
            if (!sram3_we_n) we3_low++;
            if (!sram3_oe_n) oe3_low++;
            if (sram3_oe_n && sram3_dq === 16'h5A3C) begin
                drv3++;
                if (sram3_we_n) drv3_we_high++;
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_acc(input logic w, input logic [19:0] a, input logic [3:0] b,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.be    = b[BEW-1:0];
        bus.wdata = d[DW-1:0];
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.ack && lat < 40);
        bus.req = 1'b0;
        rd = 32'(bus.rdata);
        $display("acc we=%0d addr=%h be=%h wdata=%h rdata=%h lat=%0d", w, a, b, d, rd, lat);
    endtask

    logic [31:0] rd;
    int          lat, n, acks;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en = 0; mon3_en = 0;
        lane_cnt = 0; we3_low = 0; drv3 = 0; drv3_we_high = 0; oe3_low = 0;
        bus.req = 0; bus.we = 0; bus.addr = '0; bus.be = '0; bus.wdata = '0;
        bus3.req = 0; bus3.we = 0; bus3.addr = '0; bus3.be = '0; bus3.wdata = '0;
`ifdef SRAM_CTRL_DBL_EN
        bus.wide = 1'b0;
        bus3.wide = 1'b0;
`endif
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus.ack), 32'h0);
        check("rst_rdata", 32'(bus.rdata), 32'h0);
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        reset = 1'b0;

        // Basic write then read, with latencies
        do_acc(1'b1, 20'h12345, 4'h3, 32'h0000BEEF, rd, lat);
        check("wr_lat", 32'(lat), 32'd4);
        check("wr_mem", 32'(mem[20'h12345]), 32'h0000BEEF);
        do_acc(1'b0, 20'h12345, 4'h3, 32'h0, rd, lat);
        check("rd_lat", 32'(lat), 32'd2);
        check("rd_data", rd, 32'h0000BEEF);

        // Byte lanes
        do_acc(1'b1, 20'h00100, 4'h3, 32'h0000FFFF, rd, lat);
        do_acc(1'b1, 20'h00100, 4'h2, 32'h00001234, rd, lat);
        do_acc(1'b0, 20'h00100, 4'h3, 32'h0, rd, lat);
        check("be2_merge", rd, 32'h000012FF);
        do_acc(1'b0, 20'h00100, 4'h1, 32'h0, rd, lat);
        check("rd_be1", rd, 32'h000000FF);
        do_acc(1'b0, 20'h00100, 4'h2, 32'h0, rd, lat);
        check("rd_be2", rd, 32'h00001200);

        // be=0: full sequence runs, no lane strobes, nothing written, zero read data
        lane_cnt = 0; mon_en = 1;
        do_acc(1'b1, 20'h00100, 4'h0, 32'h00000000, rd, lat);
        check("be0_wr_lat", 32'(lat), 32'd4);
        do_acc(1'b0, 20'h00100, 4'h0, 32'h0, rd, lat);
        mon_en = 0;
        check("be0_rd_lat", 32'(lat), 32'd2);
        check("be0_rdata", rd, 32'h0);
        check("be0_lanes", 32'(lane_cnt), 32'd0);
        check("be0_mem", 32'(mem[20'h00100]), 32'h000012FF);

        // req held across ack: second read accepted in the IDLE cycle after ACK
        @(posedge clk); #1;
        bus.req = 1; bus.we = 0; bus.addr = 20'h12345; bus.be = '1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.ack && n < 40);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bus.ack && n < 40);
        bus.req = 0;
        $display("acc back-to-back read addr=12345 gap=%0d", n);
        check("b2b_gap", 32'(n), 32'd3);
        check("b2b_rdata", 32'(bus.rdata), 32'h0000BEEF);

        // req pulse while busy is ignored
        do_acc(1'b1, 20'h00300, 4'h3, 32'h00000000, rd, lat);
        @(posedge clk); #1;
        bus.req = 1; bus.we = 1; bus.addr = 20'h00200; bus.be = '1; bus.wdata = DW'(32'h7777);
        @(posedge clk); #1;
        bus.req = 0;
        @(posedge clk); #1;
        bus.req = 1; bus.addr = 20'h00300; bus.wdata = DW'(32'h9999);
        @(posedge clk); #1;
        bus.req = 0;
        n = 0;
        while (!bus.ack && n < 40) begin @(posedge clk); #1; n++; end
        check("busy_ack_seen", 32'(bus.ack), 32'h1);
        acks = 0;
        repeat (8) begin @(posedge clk); #1; if (bus.ack) acks++; end
        $display("acc busy-pulse write addr=00200 extra_acks=%0d", acks);
        check("busy_no_ack", 32'(acks), 32'd0);
        check("busy_mem_a", 32'(mem[20'h00200]), 32'h00007777);
        check("busy_mem_b", 32'(mem[20'h00300]), 32'h00000000);

        // Reset during WR_PULSE
        do_acc(1'b1, 20'h00400, 4'h3, 32'h0000AAAA, rd, lat);
        do_acc(1'b0, 20'h12345, 4'h3, 32'h0, rd, lat);
        @(posedge clk); #1;
        bus.req = 1; bus.we = 1; bus.addr = 20'h00400; bus.be = '1; bus.wdata = DW'(32'h5555);
        @(posedge clk); #1;
        bus.req = 0;
        @(posedge clk); #1;
        check("pulse_pre", 32'(sram_we_n), 32'h0);
        #1 reset = 1'b1;
        #1;
        check("rstmid_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
        check("rstmid_dq_rel", 32'(sram_dq === 16'h5555), 32'h0);
        check("rstmid_rdata", 32'(bus.rdata), 32'h0);
        check("rstmid_addr", 32'(sram_addr), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        acks = 0;
        repeat (5) begin @(posedge clk); #1; if (bus.ack) acks++; end
        $display("acc reset-aborted write addr=00400 acks=%0d", acks);
        check("rstmid_no_ack", 32'(acks), 32'd0);
        check("rstmid_mem", 32'(mem[20'h00400]), 32'h0000AAAA);
        do_acc(1'b0, 20'h00400, 4'h3, 32'h0, rd, lat);
        check("post_rst_lat", 32'(lat), 32'd2);
        check("post_rst_rd", rd, 32'h0000AAAA);

`ifdef SRAM_CTRL_DBL_EN
        bus.wide = 1'b1;
        do_acc(1'b1, 20'hFFFFF, 4'hF, 32'hCAFEBABE, rd, lat);
        check("wide_mem_lo", 32'(mem[20'hFFFFF]), 32'h0000BABE);
        check("wide_mem_hi", 32'(mem[20'h00000]), 32'h0000CAFE);
        do_acc(1'b0, 20'hFFFFF, 4'hF, 32'h0, rd, lat);
        check("wide_rd", rd, 32'hCAFEBABE);
        check("wide_rd_lat", 32'(lat), 32'd3);
        @(posedge clk); #1;
        check("wide_single_ack", 32'(bus.ack), 32'h0);
        bus.wide = 1'b0;
        do_acc(1'b0, 20'hFFFFF, 4'h3, 32'h0, rd, lat);
        check("narrow_rd_hi0", rd, 32'h0000BABE);
`endif

        // WAIT=3 pin timing
        @(posedge clk); #1;
        we3_low = 0; drv3 = 0; drv3_we_high = 0; oe3_low = 0;
        bus3.req = 1; bus3.we = 1; bus3.addr = 20'h00777; bus3.be = '1; bus3.wdata = DW'(32'h5A3C);
        mon3_en = 1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            bus3.req = 0;
        end while (!bus3.ack && lat < 40);
        mon3_en = 0;
        $display("acc w3 write addr=00777 lat=%0d we_low=%0d drv=%0d", lat, we3_low, drv3);
        check("w3_wr_lat", 32'(lat), 32'd6);
        check("w3_we_low", 32'(we3_low), 32'd3);
        check("w3_dq_drv", 32'(drv3), 32'd5);
        check("w3_drv_edges", 32'(drv3_we_high), 32'd2);
        check("w3_oe_in_wr", 32'(oe3_low), 32'd0);

        @(posedge clk); #1;
        @(posedge clk); #1;
        oe3_low = 0; drv3 = 0;
        bus3.req = 1; bus3.we = 0;
        mon3_en = 1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            bus3.req = 0;
        end while (!bus3.ack && lat < 40);
        mon3_en = 0;
        $display("acc w3 read addr=00777 lat=%0d rdata=%h", lat, bus3.rdata);
        check("w3_rd_lat", 32'(lat), 32'd4);
        check("w3_oe_low", 32'(oe3_low), 32'd3);
        check("w3_rdata", 32'(bus3.rdata), 32'h0000A5C3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
